// File: rtl/register_bank.sv
// Small register file with per-register load/increment/decrement/shift-left writes,
// two tri-stateable combinational read ports and registered carry/zero flags.
module register_bank #(
   parameter int NrOfBits = 8,
   parameter int NrOfRegs = 4,
   parameter int AddrBits = 2
) (
   input  logic                Clock,
   input  logic                Reset,
   input  logic                ClockEnable,
   input  logic                Tick,
   input  logic                pre,
   input  logic                we,
   input  logic [1:0]          Mode,
   input  logic [AddrBits-1:0] WAddr,
   input  logic [NrOfBits-1:0] D,
   input  logic                ShiftIn,
   input  logic [AddrBits-1:0] RAddrA,
   input  logic [AddrBits-1:0] RAddrB,
   input  logic                csA,
   input  logic                csB,
   output logic [NrOfBits-1:0] QA,
   output logic [NrOfBits-1:0] QB,
   output logic                Carry,
   output logic                Zero
);

   localparam logic [1:0] MODE_LOAD = 2'b00;
   localparam logic [1:0] MODE_INC  = 2'b01;
   localparam logic [1:0] MODE_DEC  = 2'b10;
   localparam logic [1:0] MODE_SHL  = 2'b11;

   logic [NrOfBits-1:0] regs [NrOfRegs];
   logic [NrOfRegs-1:0] wsel;
   logic                whit;
   logic [NrOfBits-1:0] old_val;
   logic [NrOfBits-1:0] new_val;
   logic                new_carry;
   logic [NrOfBits-1:0] rd_a;
   logic [NrOfBits-1:0] rd_b;
   logic                update;

   assign update = ClockEnable & Tick;

   // Out-of-range write addresses select nothing, so registers and flags hold.
   always_comb begin
      wsel    = '0;
      whit    = 1'b0;
      old_val = '0;
      for (int i = 0; i < NrOfRegs; i++) begin
         if (WAddr == AddrBits'(i)) begin
            wsel[i] = 1'b1;
            whit    = 1'b1;
            old_val = regs[i];
         end
      end
   end

   always_comb begin
      new_val   = old_val;
      new_carry = 1'b0;
      case (Mode)
         MODE_LOAD: begin
            new_val   = D;
            new_carry = 1'b0;
         end
         MODE_INC: begin
            new_val   = old_val + 1'b1;
            new_carry = &old_val;
         end
         MODE_DEC: begin
            new_val   = old_val - 1'b1;
            new_carry = ~|old_val;
         end
         MODE_SHL: begin
            new_val   = {old_val[NrOfBits-2:0], ShiftIn};
            new_carry = old_val[NrOfBits-1];
         end
         default: begin
            new_val   = old_val;
            new_carry = 1'b0;
         end
      endcase
   end

   always_ff @(posedge Clock or posedge Reset) begin
      if (Reset) begin
         for (int i = 0; i < NrOfRegs; i++) regs[i] <= '0;
         Carry <= 1'b0;
         Zero  <= 1'b0;
      end else if (update) begin
         if (pre) begin
            for (int i = 0; i < NrOfRegs; i++) regs[i] <= '1;
            Carry <= 1'b0;
            Zero  <= 1'b0;
         end else if (we && whit) begin
            for (int i = 0; i < NrOfRegs; i++) begin
               if (wsel[i]) regs[i] <= new_val;
            end
            Carry <= new_carry;
            Zero  <= (new_val == '0);
         end
      end
   end

   // Reads see only the stored contents; there is no path from the write data.
   always_comb begin
      rd_a = '0;
      rd_b = '0;
      for (int i = 0; i < NrOfRegs; i++) begin
         if (RAddrA == AddrBits'(i)) rd_a = regs[i];
         if (RAddrB == AddrBits'(i)) rd_b = regs[i];
      end
   end

   assign QA = csA ? {NrOfBits{1'bz}} : rd_a;
   assign QB = csB ? {NrOfBits{1'bz}} : rd_b;

endmodule

// File: doc/register_bank.md
REGISTER_BANK -- requirements
Module: register_bank

Interface
REQ-001 Parameter NrOfBits, default 8: width of each register; SHALL be legal for any value >= 2.
REQ-002 Parameter NrOfRegs, default 4: number of registers; SHALL be legal for any value from 2 to 2**AddrBits.
REQ-003 Parameter AddrBits, default 2: width of every address port.
REQ-004 Clock  input  1  single system clock; all state SHALL update on its rising edge only.
REQ-005 Reset  input  1  asynchronous, active-high reset.
REQ-006 ClockEnable  input  1  update qualifier, ANDed with Tick.
REQ-007 Tick  input  1  update qualifier; "update cycle" = rising Clock with ClockEnable&Tick = 1.
REQ-008 pre  input  1  synchronous preset of all registers.
REQ-009 we  input  1  write enable.
REQ-010 Mode  input  2  write operation: 00 load, 01 increment, 10 decrement, 11 shift-left.
REQ-011 WAddr  input  AddrBits  write address.
REQ-012 D  input  NrOfBits  load data.
REQ-013 ShiftIn  input  1  LSB fill bit for shift-left.
REQ-014 RAddrA / RAddrB  input  AddrBits  read addresses, ports A and B.
REQ-015 csA / csB  input  1  output disable; high drives the matching Q port to all-Z.
REQ-016 QA / QB  output  NrOfBits  read data, tri-stateable.
REQ-017 Carry  output  1  registered carry/borrow/shift-out of the last completed write.
REQ-018 Zero  output  1  registered flag: 1 when the result of the last completed write was 0.

Function
REQ-019 Each read port SHALL be combinational from its address and the current register contents; there SHALL be no write-to-read bypass.
- A read of a register written on a given edge returns the new value only after that edge.
REQ-020 A read address >= NrOfRegs SHALL return all zeros, unless the port's cs is high (then Z).
REQ-021 QA/QB SHALL be all-Z whenever csA/csB is high, independent of any other input.
REQ-022 On an update cycle with pre = 1, every register SHALL become all-ones, Carry SHALL become 0 and Zero SHALL become 0.
- pre SHALL take priority over we.
REQ-023 On an update cycle with pre = 0 and we = 1, exactly one register at WAddr SHALL be modified according to Mode (REQ-024 to REQ-027).
REQ-024 Load (00): reg <= D; Carry <= 0.
REQ-025 Increment (01): reg <= reg+1 modulo 2**NrOfBits; Carry <= 1 only when the old value was all-ones (the value wraps to 0).
REQ-026 Decrement (10): reg <= reg-1 modulo 2**NrOfBits; Carry <= 1 only when the old value was 0 (the value wraps to all-ones).
REQ-027 Shift-left (11): reg <= {old[NrOfBits-2:0], ShiftIn}; Carry <= old MSB.
REQ-028 On every write per REQ-023, Zero SHALL be set to (new register value == 0).
REQ-029 When WAddr >= NrOfRegs, no register SHALL change, and Carry and Zero SHALL hold.
REQ-030 On a non-update cycle, or when we = 0 and pre = 0, all registers and flags SHALL hold.
REQ-031 Read and write to the same address in one cycle is legal; the read returns the pre-edge value.

Reset
REQ-032 Reset high SHALL immediately, without waiting for a clock edge, clear all registers to 0 and clear Carry and Zero to 0.
REQ-033 Reset SHALL override pre, we and the clock for as long as it is high.
REQ-034 Reset asserted mid-operation SHALL discard any pending write.
REQ-035 The first update cycle after Reset deasserts SHALL behave normally.
REQ-036 Tri-state control SHALL be unaffected by Reset; with cs low, Q shows 0 during reset.

Verification
REQ-037 Load then read (NrOfBits=8): Reset; load 0xA5 into reg 2; RAddrA=2, csA=0 -> QA=0xA5 after the edge, 0x00 before it; Carry=0, Zero=0.
REQ-038 Increment wrap: load 0xFF into reg 1, then increment reg 1 -> reg 1 = 0x00, Carry=1, Zero=1.
- A further decrement of reg 1 -> reg 1 = 0xFF, Carry=1, Zero=0.
REQ-039 Shift: load 0x81 into reg 0, shift with ShiftIn=1 -> 0x03, Carry=1; shift with ShiftIn=0 -> 0x06, Carry=0.
REQ-040 Enables and priority: we=1 with Tick=0 -> no change; pre=1 and we=1 together -> all registers 0xFF, Carry=0, Zero=0.
- WAddr=5 with NrOfRegs=4 -> no register or flag changes.
REQ-041 Async reset and tri-state: assert Reset between clock edges -> QA=0x00 immediately and flags 0.
- csB=1 -> QB=Z for all RAddrB values, including out-of-range addresses.
